// File: rtl/lpif_pkg.sv
// Shared LPIF link-state codes, transmit grant encoding and bus sizing helpers.
package lpif_pkg;

  localparam logic [3:0] LPIF_STS_RESET  = 4'h0;
  localparam logic [3:0] LPIF_STS_ACTIVE = 4'h1;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_TLP  = 2'd1,
    GNT_DLLP = 2'd2
  } tx_grant_e;

  // Number of byte lanes on a bus of the given bit width.
  function automatic int unsigned lpif_lanes(input int unsigned width_bits);
    return width_bits / 8;
  endfunction

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int unsigned lpif_cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lpif_tx_out_stage.sv
// Single register stage driving lp_* toward the PHY; owns the irdy/trdy handshake.
module lpif_tx_out_stage
  import lpif_pkg::*;
#(
  parameter  int unsigned W  = 32,
  localparam int unsigned B  = lpif_lanes(W),
  localparam int unsigned FW = 6 * B
) (
  input  logic          lclk,
  input  logic          reset_n,
  input  logic          link_active_i,
  input  logic          load_i,
  input  logic          pl_trdy_i,
  input  logic [W-1:0]  data_i,
  input  logic [FW-1:0] frame_i,
  output logic          load_ok_c,
  output logic          irdy_o,
  output logic [W-1:0]  data_o,
  output logic [FW-1:0] frame_o
);

  logic          irdy_q,  irdy_d;
  logic [W-1:0]  data_q,  data_d;
  logic [FW-1:0] frame_q, frame_d;

  // Register is free when empty or its beat is being taken this cycle.
  assign load_ok_c = !irdy_q || pl_trdy_i;

  always_comb begin
    irdy_d  = irdy_q;
    data_d  = data_q;
    frame_d = frame_q;
    if (!link_active_i) begin
      irdy_d  = 1'b0;
      frame_d = '0;
    end else if (load_i) begin
      irdy_d  = 1'b1;
      data_d  = data_i;
      frame_d = frame_i;
    end else if (irdy_q && pl_trdy_i) begin
      irdy_d  = 1'b0;
      frame_d = '0;
    end
  end

  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      irdy_q  <= 1'b0;
      data_q  <= '0;
      frame_q <= '0;
    end else begin
      irdy_q  <= irdy_d;
      data_q  <= data_d;
      frame_q <= frame_d;
    end
  end

  assign irdy_o  = irdy_q;
  assign data_o  = data_q;
  assign frame_o = frame_q;

endmodule

// File: rtl/lpif_tx_arbiter.sv
// LPIF transmit scheduler: arbitrates TLP and DLLP packets onto one registered
// lp_* beat stream, with DLLP priority limited by a burst counter.
module lpif_tx_arbiter
  import lpif_pkg::*;
#(
  parameter  int unsigned LPIF_BUS_WIDTH = 32,
  parameter  int unsigned DLLP_BURST_MAX = 4,
  localparam int unsigned W  = LPIF_BUS_WIDTH,
  localparam int unsigned B  = lpif_lanes(LPIF_BUS_WIDTH),
  localparam int unsigned FW = 6 * B,
  localparam int unsigned CW = lpif_cnt_width(DLLP_BURST_MAX)
) (
  input  logic         lclk,
  input  logic         reset_n,
  input  logic [3:0]   pl_state_sts,
  input  logic         pl_trdy,
  input  logic         tlp_valid,
  output logic         tlp_ready,
  input  logic [W-1:0] tlp_data,
  input  logic [B-1:0] tlp_ben,
  input  logic [B-1:0] tlp_start,
  input  logic [B-1:0] tlp_end,
  input  logic [B-1:0] tlp_edb,
  input  logic         dllp_valid,
  output logic         dllp_ready,
  input  logic [W-1:0] dllp_data,
  input  logic [B-1:0] dllp_ben,
  input  logic [B-1:0] dllp_start,
  input  logic [B-1:0] dllp_end,
  output logic         lp_irdy,
  output logic [W-1:0] lp_data,
  output logic [B-1:0] lp_valid,
  output logic [B-1:0] lp_tlp_start,
  output logic [B-1:0] lp_tlp_end,
  output logic [B-1:0] lp_tlpedb,
  output logic [B-1:0] lp_dllp_start,
  output logic [B-1:0] lp_dllp_end,
  output logic [1:0]   tx_abort
);

  tx_grant_e     state_q, state_d, grant_c;
  logic [CW-1:0] burst_q, burst_d;
  logic [1:0]    abort_q, abort_d;

  logic          link_active_c;
  logic          load_ok_c;
  logic          burst_full_c;
  logic          tlp_acc_c, dllp_acc_c;
  logic          tlp_done_c, dllp_done_c;
  logic [W-1:0]  beat_data_c;
  logic [FW-1:0] beat_frame_c;
  logic [FW-1:0] frame_out;

  assign link_active_c = (pl_state_sts == LPIF_STS_ACTIVE);
  assign burst_full_c  = (burst_q == CW'(DLLP_BURST_MAX));

  // Grant, readies, packet ownership and burst accounting.
  always_comb begin
    grant_c     = state_q;
    state_d     = state_q;
    burst_d     = burst_q;
    abort_d     = 2'b00;
    tlp_ready   = 1'b0;
    dllp_ready  = 1'b0;
    tlp_acc_c   = 1'b0;
    dllp_acc_c  = 1'b0;
    tlp_done_c  = 1'b0;
    dllp_done_c = 1'b0;

    if (state_q == GNT_IDLE) begin
      grant_c = GNT_IDLE;
      if (dllp_valid && !(tlp_valid && burst_full_c)) begin
        grant_c = GNT_DLLP;
      end else if (tlp_valid) begin
        grant_c = GNT_TLP;
      end
    end

    tlp_ready   = link_active_c && load_ok_c && (grant_c == GNT_TLP);
    dllp_ready  = link_active_c && load_ok_c && (grant_c == GNT_DLLP);
    tlp_acc_c   = tlp_valid && tlp_ready;
    dllp_acc_c  = dllp_valid && dllp_ready;
    tlp_done_c  = tlp_acc_c && (|tlp_end);
    dllp_done_c = dllp_acc_c && (|dllp_end);

    if (!link_active_c) begin
      state_d = GNT_IDLE;
      burst_d = '0;
      abort_d = {state_q == GNT_DLLP, state_q == GNT_TLP};
    end else begin
      if (tlp_done_c || dllp_done_c) begin
        state_d = GNT_IDLE;
      end else if (tlp_acc_c || dllp_acc_c) begin
        state_d = grant_c;
      end
      if (tlp_done_c || !tlp_valid) begin
        burst_d = '0;
      end else if (dllp_done_c && !burst_full_c) begin
        burst_d = burst_q + CW'(1);
      end
    end
  end

  always_ff @(posedge lclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= GNT_IDLE;
      burst_q <= '0;
      abort_q <= 2'b00;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      abort_q <= abort_d;
    end
  end

  // Frame layout: {valid, tlp_start, tlp_end, tlp_edb, dllp_start, dllp_end}.
  always_comb begin
    beat_data_c  = tlp_data;
    beat_frame_c = {tlp_ben, tlp_start, tlp_end, tlp_edb, {(2*B){1'b0}}};
    if (grant_c == GNT_DLLP) begin
      beat_data_c  = dllp_data;
      beat_frame_c = {dllp_ben, {(3*B){1'b0}}, dllp_start, dllp_end};
    end
  end

  lpif_tx_out_stage #(
    .W (W)
  ) u_out_stage (
    .lclk          (lclk),
    .reset_n       (reset_n),
    .link_active_i (link_active_c),
    .load_i        (tlp_acc_c || dllp_acc_c),
    .pl_trdy_i     (pl_trdy),
    .data_i        (beat_data_c),
    .frame_i       (beat_frame_c),
    .load_ok_c     (load_ok_c),
    .irdy_o        (lp_irdy),
    .data_o        (lp_data),
    .frame_o       (frame_out)
  );

  assign {lp_valid, lp_tlp_start, lp_tlp_end, lp_tlpedb, lp_dllp_start, lp_dllp_end} = frame_out;
  assign tx_abort = abort_q;

endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// Bench for lpif_tx_arbiter: directed LPIF scenarios plus randomized traffic
// checked against a packet-level reference model of the scheduler.
module tb_lpif_tx_arbiter;

  localparam int         MAXB = 4;
  localparam logic [3:0] ACT  = 4'h1;
  localparam logic [3:0] DOWN = 4'h0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ben;
    logic [3:0]  st;
    logic [3:0]  en;
    logic [3:0]  edb;
  } beat_t;

  logic        lclk;
  logic        reset_n;
  logic [3:0]  pl_state_sts;
  logic        pl_trdy;
  logic        tlp_valid, tlp_ready;
  logic [31:0] tlp_data;
  logic [3:0]  tlp_ben, tlp_start, tlp_end, tlp_edb;
  logic        dllp_valid, dllp_ready;
  logic [31:0] dllp_data;
  logic [3:0]  dllp_ben, dllp_start, dllp_end;
  logic        lp_irdy;
  logic [31:0] lp_data;
  logic [3:0]  lp_valid, lp_tlp_start, lp_tlp_end, lp_tlpedb, lp_dllp_start, lp_dllp_end;
  logic [1:0]  tx_abort;

  lpif_tx_arbiter #(
    .LPIF_BUS_WIDTH (32),
    .DLLP_BURST_MAX (4)
  ) dut (
    .lclk          (lclk),
    .reset_n       (reset_n),
    .pl_state_sts  (pl_state_sts),
    .pl_trdy       (pl_trdy),
    .tlp_valid     (tlp_valid),
    .tlp_ready     (tlp_ready),
    .tlp_data      (tlp_data),
    .tlp_ben       (tlp_ben),
    .tlp_start     (tlp_start),
    .tlp_end       (tlp_end),
    .tlp_edb       (tlp_edb),
    .dllp_valid    (dllp_valid),
    .dllp_ready    (dllp_ready),
    .dllp_data     (dllp_data),
    .dllp_ben      (dllp_ben),
    .dllp_start    (dllp_start),
    .dllp_end      (dllp_end),
    .lp_irdy       (lp_irdy),
    .lp_data       (lp_data),
    .lp_valid      (lp_valid),
    .lp_tlp_start  (lp_tlp_start),
    .lp_tlp_end    (lp_tlp_end),
    .lp_tlpedb     (lp_tlpedb),
    .lp_dllp_start (lp_dllp_start),
    .lp_dllp_end   (lp_dllp_end),
    .tx_abort      (tx_abort)
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  // Source packet queues and reference-model state.
  beat_t      tq[$];
  beat_t      dq[$];
  int         owner;   // 0 none, 1 TLP owns the bus, 2 DLLP owns the bus
  int         burst;   // DLLPs finished while a TLP has been waiting
  bit         m_irdy;
  bit         m_tlp;
  beat_t      m_beat;
  logic [1:0] m_abort;
  bit         e_tready, e_dready;
  logic       s_tready, s_dready;
  int         n_vec, n_err;

  task automatic push_pkt(input bit is_tlp, input int nb);
    beat_t      b;
    logic [3:0] full;
    full = 4'hF;
    for (int i = 0; i < nb; i++) begin
      b.data = $urandom;
      b.ben  = (i == nb - 1) ? (full >> $urandom_range(0, 3)) : 4'hF;
      b.st   = (i == 0) ? 4'h1 : 4'h0;
      b.en   = (i == nb - 1) ? (b.ben ^ (b.ben >> 1)) : 4'h0;
      b.edb  = (is_tlp && i == nb - 1 && $urandom_range(0, 7) == 0) ? b.en : 4'h0;
      if (is_tlp) tq.push_back(b);
      else        dq.push_back(b);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model, return at posedge+1.
  task automatic cycle(input bit ten, input bit den, input bit trdy, input logic [3:0] sts);
    bit    act, lok, tv, dv, tacc, dacc, tend, dend, fin;
    beat_t tb, db, x;
    tv = ten && (tq.size() > 0);
    dv = den && (dq.size() > 0);
    tb = (tq.size() > 0) ? tq[0] : '0;
    db = (dq.size() > 0) ? dq[0] : '0;
    tlp_valid  = tv;  tlp_data  = tb.data; tlp_ben  = tb.ben;
    tlp_start  = tb.st; tlp_end = tb.en;   tlp_edb  = tb.edb;
    dllp_valid = dv;  dllp_data = db.data; dllp_ben = db.ben;
    dllp_start = db.st; dllp_end = db.en;
    pl_trdy = trdy;
    pl_state_sts = sts;
    act = (sts == ACT);
    lok = !m_irdy || trdy;
    e_tready = 1'b0;
    e_dready = 1'b0;
    if (act && lok) begin
      if (owner == 1)                            e_tready = 1'b1;
      else if (owner == 2)                       e_dready = 1'b1;
      else if (dv && !(tv && burst == MAXB))     e_dready = 1'b1;
      else if (tv)                               e_tready = 1'b1;
    end
    #1;
    s_tready = tlp_ready;
    s_dready = dllp_ready;
    tacc = tv && e_tready;
    dacc = dv && e_dready;
    tend = tacc && (tb.en != 4'h0);
    dend = dacc && (db.en != 4'h0);
    m_abort = 2'b00;
    if (!act) begin
      m_abort = {owner == 2, owner == 1};
      fin = 1'b0;
      while (owner == 1 && !fin && tq.size() > 0) begin
        fin = (tq[0].en != 4'h0);
        x = tq.pop_front();
      end
      fin = 1'b0;
      while (owner == 2 && !fin && dq.size() > 0) begin
        fin = (dq[0].en != 4'h0);
        x = dq.pop_front();
      end
      owner  = 0;
      burst  = 0;
      m_irdy = 1'b0;
    end else begin
      if (tacc) begin
        m_irdy = 1'b1; m_beat = tb; m_tlp = 1'b1;
        owner = tend ? 0 : 1;
        x = tq.pop_front();
      end else if (dacc) begin
        m_irdy = 1'b1; m_beat = db; m_tlp = 1'b0;
        owner = dend ? 0 : 2;
        x = dq.pop_front();
      end else if (m_irdy && trdy) begin
        m_irdy = 1'b0;
      end
      if (tend || !tv)                 burst = 0;
      else if (dend && burst < MAXB)   burst++;
    end
    @(posedge lclk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_tlpedb, lp_dllp_start,
         lp_dllp_end, tx_abort, tlp_ready, dllp_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: irdy=%b data=%h valid=%h abort=%b rdy=%b%b want all 0",
               lp_irdy, lp_data, lp_valid, tx_abort, tlp_ready, dllp_ready);
    end
    @(negedge lclk);
    reset_n = 1'b1;
    @(posedge lclk);
    #1;
    n_vec++;
    if ({lp_irdy, lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, tx_abort} !== '0) begin
      n_err++;
      $display("FAIL reset_release: irdy=%b valid=%h abort=%b want 0", lp_irdy, lp_valid, tx_abort);
    end
  endtask

  task automatic test_single_tlp();
    beat_t exp[$];
    push_pkt(1'b1, 3);
    exp = tq;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b1, ACT);
      n_vec++;
      if (s_tready !== (i < 3)) begin
        n_err++;
        $display("FAIL single_tlp_ready beat %0d: got %b want %b", i, s_tready, (i < 3));
      end
      n_vec++;
      if (lp_irdy !== (i < 3)) begin
        n_err++;
        $display("FAIL single_tlp_irdy beat %0d: got %b want %b", i, lp_irdy, (i < 3));
      end
      if (i < 3) begin
        n_vec++;
        if ({lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end} !==
            {exp[i].data, exp[i].ben, exp[i].st, exp[i].en, 8'h00}) begin
          n_err++;
          $display("FAIL single_tlp_beat %0d: got %h/%h s%h e%h want %h/%h s%h e%h", i,
                   lp_data, lp_valid, lp_tlp_start, lp_tlp_end,
                   exp[i].data, exp[i].ben, exp[i].st, exp[i].en);
        end
      end
    end
  endtask

  task automatic test_dllp_first();
    beat_t exp[$];
    bit    is_t[$];
    push_pkt(1'b0, 2);
    push_pkt(1'b1, 2);
    foreach (dq[k]) begin exp.push_back(dq[k]); is_t.push_back(1'b0); end
    foreach (tq[k]) begin exp.push_back(tq[k]); is_t.push_back(1'b1); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, ACT);
      n_vec++;
      if (lp_irdy !== 1'b1 ||
          {lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end} !==
          {exp[i].data, exp[i].ben,
           is_t[i] ? exp[i].st : 4'h0, is_t[i] ? exp[i].en : 4'h0,
           is_t[i] ? 4'h0 : exp[i].st, is_t[i] ? 4'h0 : exp[i].en}) begin
        n_err++;
        $display("FAIL dllp_first slot %0d: irdy=%b data=%h tst=%h dst=%h want data=%h tlp=%b",
                 i, lp_irdy, lp_data, lp_tlp_start, lp_dllp_start, exp[i].data, is_t[i]);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, ACT);
  endtask

  task automatic test_burst();
    int seq[$];
    int want[6];
    want = '{2, 2, 2, 2, 1, 2};
    for (int k = 0; k < 5; k++) push_pkt(1'b0, 2);
    push_pkt(1'b1, 2);
    for (int c = 0; c < 14; c++) begin
      cycle(1'b1, 1'b1, 1'b1, ACT);
      if (lp_irdy && lp_dllp_start != 4'h0)     seq.push_back(2);
      else if (lp_irdy && lp_tlp_start != 4'h0) seq.push_back(1);
    end
    n_vec++;
    if (seq.size() != 6) begin
      n_err++;
      $display("FAIL burst_count: got %0d packets want 6", seq.size());
    end
    for (int i = 0; i < 6 && i < seq.size(); i++) begin
      n_vec++;
      if (seq[i] != want[i]) begin
        n_err++;
        $display("FAIL burst_order pkt %0d: got type %0d want %0d (1=TLP 2=DLLP)", i, seq[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t       exp[$];
    logic [31:0] got[$];
    push_pkt(1'b1, 4);
    exp = tq;
    for (int c = 0; c < 12; c++) begin
      bit trdy;
      trdy = !(c >= 2 && c < 7);
      if (lp_irdy && trdy) got.push_back(lp_data);
      cycle(1'b1, 1'b0, trdy, ACT);
      if (!trdy) begin
        n_vec++;
        if (s_tready !== 1'b0 || lp_irdy !== 1'b1 || lp_data !== exp[1].data) begin
          n_err++;
          $display("FAIL stall_hold cyc %0d: ready=%b irdy=%b data=%h want 0 1 %h",
                   c, s_tready, lp_irdy, lp_data, exp[1].data);
        end
      end
    end
    n_vec++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL stall_delivered: got %0d beats want 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== exp[i].data) begin
        n_err++;
        $display("FAIL stall_order beat %0d: got %h want %h", i, got[i], exp[i].data);
      end
    end
  endtask

  task automatic test_link_drop();
    push_pkt(1'b1, 4);
    cycle(1'b1, 1'b0, 1'b1, ACT);
    cycle(1'b1, 1'b0, 1'b1, ACT);
    cycle(1'b1, 1'b0, 1'b1, DOWN);
    n_vec++;
    if (s_tready !== 1'b0 || lp_irdy !== 1'b0 || tx_abort !== 2'b01) begin
      n_err++;
      $display("FAIL drop_abort: ready=%b irdy=%b abort=%b want 0 0 01", s_tready, lp_irdy, tx_abort);
    end
    push_pkt(1'b1, 2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, DOWN);
      n_vec++;
      if (s_tready !== 1'b0 || lp_irdy !== 1'b0 || tx_abort !== 2'b00) begin
        n_err++;
        $display("FAIL drop_idle cyc %0d: ready=%b irdy=%b abort=%b want 0 0 00",
                 i, s_tready, lp_irdy, tx_abort);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, ACT);
    n_vec++;
    if (s_tready !== 1'b1 || lp_irdy !== 1'b1 || lp_tlp_start !== 4'h1) begin
      n_err++;
      $display("FAIL drop_resume: ready=%b irdy=%b tst=%h want 1 1 1", s_tready, lp_irdy, lp_tlp_start);
    end
    cycle(1'b1, 1'b0, 1'b1, ACT);
    cycle(1'b0, 1'b0, 1'b1, ACT);
  endtask

  task automatic test_async_reset();
    push_pkt(1'b1, 4);
    cycle(1'b1, 1'b0, 1'b1, ACT);
    cycle(1'b1, 1'b0, 1'b1, ACT);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({lp_irdy, lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_tlpedb, lp_dllp_start,
         lp_dllp_end, tx_abort} !== '0) begin
      n_err++;
      $display("FAIL async_reset: irdy=%b data=%h valid=%h abort=%b want all 0",
               lp_irdy, lp_data, lp_valid, tx_abort);
    end
    tq.delete();
    dq.delete();
    owner = 0; burst = 0; m_irdy = 1'b0;
    tlp_valid = 1'b0;
    dllp_valid = 1'b0;
    #1;
    n_vec++;
    if (tlp_ready !== 1'b0 || dllp_ready !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_ready: got %b%b want 00", tlp_ready, dllp_ready);
    end
    @(negedge lclk);
    reset_n = 1'b1;
    @(posedge lclk);
    #1;
    push_pkt(1'b0, 1);
    push_pkt(1'b1, 1);
    cycle(1'b1, 1'b1, 1'b1, ACT);
    n_vec++;
    if (s_dready !== 1'b1 || s_tready !== 1'b0 || lp_irdy !== 1'b1 || lp_dllp_start !== 4'h1) begin
      n_err++;
      $display("FAIL post_reset_grant: drdy=%b trdy=%b irdy=%b dst=%h want 1 0 1 1",
               s_dready, s_tready, lp_irdy, lp_dllp_start);
    end
    cycle(1'b1, 1'b1, 1'b1, ACT);
    cycle(1'b0, 1'b0, 1'b1, ACT);
  endtask

  task automatic test_random(input int ncyc);
    logic [3:0]  sts;
    logic [55:0] exp_v, got_v;
    int          down;
    down = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (tq.size() < 6) push_pkt(1'b1, $urandom_range(1, 5));
      if (dq.size() < 4) push_pkt(1'b0, $urandom_range(1, 2));
      if (down > 0) down--;
      else if ($urandom_range(0, 79) == 0) down = $urandom_range(1, 3);
      sts = (down > 0) ? (($urandom_range(0, 1) == 0) ? DOWN : 4'h3) : ACT;
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, sts);
      n_vec++;
      if (s_tready !== e_tready || s_dready !== e_dready) begin
        n_err++;
        $display("FAIL rnd_ready cyc %0d: got tlp=%b dllp=%b want tlp=%b dllp=%b",
                 c, s_tready, s_dready, e_tready, e_dready);
      end
      n_vec++;
      if (lp_irdy !== m_irdy) begin
        n_err++;
        $display("FAIL rnd_irdy cyc %0d: got %b want %b", c, lp_irdy, m_irdy);
      end
      got_v = {lp_data, lp_valid, lp_tlp_start, lp_tlp_end, lp_tlpedb, lp_dllp_start, lp_dllp_end};
      exp_v = {m_beat.data, m_beat.ben,
               m_tlp ? m_beat.st : 4'h0, m_tlp ? m_beat.en : 4'h0, m_tlp ? m_beat.edb : 4'h0,
               m_tlp ? 4'h0 : m_beat.st, m_tlp ? 4'h0 : m_beat.en};
      n_vec++;
      if (m_irdy ? (got_v !== exp_v) : (got_v[23:0] !== 24'h0)) begin
        n_err++;
        $display("FAIL rnd_beat cyc %0d: got %h want %h (irdy %b)", c, got_v, exp_v, m_irdy);
      end
      n_vec++;
      if (tx_abort !== m_abort) begin
        n_err++;
        $display("FAIL rnd_abort cyc %0d: got %b want %b", c, tx_abort, m_abort);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    owner = 0; burst = 0; m_irdy = 1'b0; m_tlp = 1'b0; m_beat = '0; m_abort = 2'b00;
    reset_n = 1'b0;
    pl_state_sts = DOWN; pl_trdy = 1'b0;
    tlp_valid = 1'b0;  tlp_data = '0;  tlp_ben = '0;  tlp_start = '0;  tlp_end = '0;  tlp_edb = '0;
    dllp_valid = 1'b0; dllp_data = '0; dllp_ben = '0; dllp_start = '0; dllp_end = '0;
    repeat (3) @(posedge lclk);
    test_reset();
    test_single_tlp();
    test_dllp_first();
    test_burst();
    test_backpressure();
    test_link_drop();
    test_async_reset();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
